// File: rtl/bidir_pkg.sv
// Shared types and helpers for the bidirectional pad direction controller.
// State encoding and turnaround counter sizing live here.
package bidir_pkg;

    typedef enum logic [1:0] {
        IN       = 2'd0,
        TURN_OUT = 2'd1,
        OUT      = 2'd2,
        TURN_IN  = 2'd3
    } dir_state_e;

    // Turnaround counter width, never narrower than one bit
    function automatic int cnt_width(input int turnaround);
        int w;
        w = $clog2(turnaround + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bidir_sync.sv
// WIDTH-bit two-flop synchroniser for pad_in.
// Only instantiated when BIDIR_DIR_CTRL_SYNC_EN is defined.
module bidir_sync
    import bidir_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s1_d;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] s2_d;

    // Next values of the two synchroniser stages
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Synchroniser stage registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/bidir_dir_ctrl.sv
// Direction controller for one level-shifted bidirectional pad group.
// Optional macro BIDIR_DIR_CTRL_SYNC_EN adds a 2-flop pad_in synchroniser.
module bidir_dir_ctrl
    import bidir_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TURNAROUND = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_out,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             is_out,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic             pad_oe,
    output logic             pad_dir
);

    localparam int CW = cnt_width(TURNAROUND);
    localparam logic [CW-1:0] CNT_LOAD = CW'(TURNAROUND - 1);

    if (TURNAROUND < 1) begin : g_bad_turnaround
        $error("bidir_dir_ctrl: TURNAROUND must be at least 1");
    end

    dir_state_e       state_q;
    dir_state_e       state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] pad_out_q;
    logic [WIDTH-1:0] pad_out_d;
    logic             pad_oe_q;
    logic             pad_oe_d;
    logic             pad_dir_q;
    logic             pad_dir_d;
    logic             is_out_q;
    logic             is_out_d;
    logic [WIDTH-1:0] rx_data_q;
    logic [WIDTH-1:0] rx_data_d;
    logic             rx_valid_q;
    logic             rx_valid_d;

    logic             in_mode;
    logic             hs;
    logic [WIDTH-1:0] rx_sample;
    logic             capture_en;

    assign in_mode  = (state_q == IN);
    assign tx_ready = (state_q == OUT) && req_out;
    assign hs       = tx_valid && tx_ready;

`ifdef BIDIR_DIR_CTRL_SYNC_EN
    logic [1:0] vpipe_q;
    logic [1:0] vpipe_d;

    bidir_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pad_in),
        .q       (rx_sample)
    );

    // Tag each synchroniser slot with whether it was sampled in IN
    always_comb begin
        vpipe_d = {vpipe_q[0], in_mode};
    end

    // Validity tags travel alongside the synchroniser stages
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vpipe_q <= '0;
        end else begin
            vpipe_q <= vpipe_d;
        end
    end

    assign capture_en = in_mode && vpipe_q[1];
`else
    assign rx_sample  = pad_in;
    assign capture_en = in_mode;
`endif

    // Next-state, turnaround counter and registered output values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pad_out_d = pad_out_q;
        rx_data_d = rx_data_q;
        unique case (state_q)
            IN: begin
                if (req_out) begin
                    state_d = TURN_OUT;
                    cnt_d   = CNT_LOAD;
                end
            end
            TURN_OUT: begin
                if (cnt_q == '0) begin
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            OUT: begin
                if (hs) begin
                    pad_out_d = tx_data;
                end
                if (!req_out) begin
                    state_d = TURN_IN;
                    cnt_d   = CNT_LOAD;
                end
            end
            TURN_IN: begin
                if (cnt_q == '0) begin
                    state_d = IN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IN;
                cnt_d   = '0;
            end
        endcase
        pad_dir_d  = (state_d != IN);
        pad_oe_d   = (state_d == OUT);
        is_out_d   = (state_d == OUT);
        rx_valid_d = capture_en;
        if (capture_en) begin
            rx_data_d = rx_sample;
        end
    end

    // State, counter and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IN;
            cnt_q      <= '0;
            pad_out_q  <= '0;
            pad_oe_q   <= 1'b0;
            pad_dir_q  <= 1'b0;
            is_out_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pad_out_q  <= pad_out_d;
            pad_oe_q   <= pad_oe_d;
            pad_dir_q  <= pad_dir_d;
            is_out_q   <= is_out_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign pad_out  = pad_out_q;
    assign pad_oe   = pad_oe_q;
    assign pad_dir  = pad_dir_q;
    assign is_out   = is_out_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_bidir_dir_ctrl.sv
// Directed bench for bidir_dir_ctrl (WIDTH=8, TURNAROUND=2).
// Byte results are predicted into a scoreboard queue and popped on output.
module tb_bidir_dir_ctrl;

    localparam int W = 8;
`ifdef BIDIR_DIR_CTRL_SYNC_EN
    localparam int RXLAT = 3;
`else
    localparam int RXLAT = 1;
`endif

    typedef struct {
        string        tag;
        logic [W-1:0] val;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         req_out;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         is_out;
    logic [W-1:0] pad_in;
    logic [W-1:0] pad_out;
    logic         pad_oe;
    logic         pad_dir;

    int   checks;
    int   errors;
    bit   mon_en;
    exp_t sb[$];

    bidir_dir_ctrl #(
        .WIDTH      (W),
        .TURNAROUND (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_out  (req_out),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .is_out   (is_out),
        .pad_in   (pad_in),
        .pad_out  (pad_out),
        .pad_oe   (pad_oe),
        .pad_dir  (pad_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [W-1:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [W-1:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed %0h expected none", obs);
        end else begin
            e = sb.pop_front();
            chk(e.tag, {24'd0, obs}, {24'd0, e.val});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // pad_oe must never be high without pad_dir
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            assert (!pad_oe || pad_dir) else begin
                errors++;
                $error("FAIL oe_implies_dir: observed oe=%0b dir=%0b expected dir=1",
                       pad_oe, pad_dir);
            end
        end
    end

    initial begin
        logic [5:0] exp_dir;
        logic [5:0] exp_oe;
        int         oe_cnt;
        checks   = 0;
        errors   = 0;
        mon_en   = 1'b0;
        reset_n  = 1'b0;
        req_out  = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        pad_in   = 8'hA5;

        // 1: reset values, then idle capture
        #2;
        mon_en = 1'b1;
        chk("rst_pad_oe", pad_oe, 0);
        chk("rst_pad_dir", pad_dir, 0);
        chk("rst_pad_out", pad_out, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_is_out", is_out, 0);
        step();
        reset_n = 1'b1;
        sb_push("idle_rx_data", 8'hA5);
        repeat (RXLAT) step();
        chk("idle_rx_valid", rx_valid, 1);
        sb_pop(rx_data);
        chk("idle_pad_dir", pad_dir, 0);
        chk("idle_pad_oe", pad_oe, 0);

        // 2: go out, then transfer 0x3C
        req_out = 1'b1;
        step();
        chk("to_c1_dir", pad_dir, 1);
        chk("to_c1_oe", pad_oe, 0);
        chk("to_c1_ready", tx_ready, 0);
        pad_in = 8'h77;
        step();
        chk("to_c2_dir", pad_dir, 1);
        chk("to_c2_oe", pad_oe, 0);
        chk("to_c2_rx_valid", rx_valid, 0);
        step();
        chk("to_c3_oe", pad_oe, 1);
        chk("to_c3_ready", tx_ready, 1);
        chk("to_c3_is_out", is_out, 1);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        sb_push("tx_3c", 8'h3C);
        step();
        tx_valid = 1'b0;
        sb_pop(pad_out);
        chk("out_hold_rx_data", rx_data, 8'hA5);

        // 3: go back in, TURN_IN samples are not captured
        req_out = 1'b0;
        pad_in  = 8'h5A;
        step();
        chk("ti_c1_oe", pad_oe, 0);
        chk("ti_c1_dir", pad_dir, 1);
        chk("ti_c1_ready", tx_ready, 0);
        chk("ti_c1_is_out", is_out, 0);
        step();
        chk("ti_c2_dir", pad_dir, 1);
        chk("ti_c2_rx_data", rx_data, 8'hA5);
        step();
        chk("ti_c3_dir", pad_dir, 0);
        chk("ti_c3_rx_valid", rx_valid, 0);
        chk("ti_c3_rx_data", rx_data, 8'hA5);
        sb_push("reenter_rx_data", 8'h5A);
        repeat (RXLAT) step();
        chk("reenter_rx_valid", rx_valid, 1);
        sb_pop(rx_data);

        // 6: tx_valid held before OUT produces no transfer
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        req_out  = 1'b1;
        step();
        chk("early_c1_pad_out", pad_out, 8'h3C);
        chk("early_c1_ready", tx_ready, 0);
        step();
        chk("early_c2_pad_out", pad_out, 8'h3C);
        step();
        chk("early_c3_pad_out", pad_out, 8'h3C);
        chk("early_c3_ready", tx_ready, 1);
        sb_push("tx_11", 8'h11);
        step();
        tx_valid = 1'b0;
        sb_pop(pad_out);
        req_out = 1'b0;
        repeat (3) step();
        chk("back_in_dir", pad_dir, 0);

        // 4: one-cycle req_out pulse runs the full sequence
        exp_dir = 6'b011111;
        exp_oe  = 6'b000100;
        oe_cnt  = 0;
        req_out = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            req_out = 1'b0;
            chk($sformatf("pulse_dir_c%0d", i + 1), pad_dir, exp_dir[i]);
            chk($sformatf("pulse_oe_c%0d", i + 1), pad_oe, exp_oe[i]);
            if (pad_oe) oe_cnt++;
        end
        chk("pulse_oe_cycles", oe_cnt, 1);

        // 5: asynchronous reset while driving 0xFF
        req_out  = 1'b1;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        repeat (3) step();
        sb_push("tx_ff", 8'hFF);
        step();
        tx_valid = 1'b0;
        sb_pop(pad_out);
        chk("pre_rst_oe", pad_oe, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_oe", pad_oe, 0);
        chk("arst_dir", pad_dir, 0);
        chk("arst_pad_out", pad_out, 0);
        chk("arst_is_out", is_out, 0);
        chk("arst_ready", tx_ready, 0);
        req_out = 1'b0;
        #1;
        reset_n = 1'b1;
        step();
        chk("post_rst_dir", pad_dir, 0);
        chk("post_rst_oe", pad_oe, 0);
        chk("sb_drained", sb.size(), 0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
